// File: rtl/xor_share_pkg.sv
// Shared types and defaults for the XOR datapath sharing controller.
package xor_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int DEF_N      = 2;
    localparam int DEF_W      = 4;
    localparam int DEF_DP_LAT = 1;
    localparam int CNT_W      = 3;

endpackage

// File: rtl/xor_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request searching from last+1.
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [N-1:0]   grant_oh,
    output logic [IDW-1:0] grant_idx,
    output logic           any_req
);

    always_comb begin
        int idx;
        idx       = 0;
        grant_oh  = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!any_req && req[idx]) begin
                any_req       = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/xor_share_ctrl.sv
// Shares one XOR datapath among N requesters: arbitrate, issue one dp_en pulse,
// wait the fixed datapath latency, then hold the result on a valid/ready channel.
module xor_share_ctrl
    import xor_share_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int W      = DEF_W,
    parameter int DP_LAT = DEF_DP_LAT,
    parameter int IDW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [W-1:0]   dp_a,
    output logic [W-1:0]   dp_b,
    output logic           dp_en,
    input  logic [W-1:0]   dp_z,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IDW-1:0] rsp_id,
    output logic [W-1:0]   rsp_z,
    output logic           busy
);

    state_e           state_q, state_d;
    logic [W-1:0]     dp_a_q, dp_a_d, dp_b_q, dp_b_d, rsp_z_q, rsp_z_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d, last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dp_en_q, dp_en_d, rsp_valid_q, rsp_valid_d, busy_q, busy_d;

    logic [N-1:0]     grant_oh;
    logic [IDW-1:0]   grant_idx;
    logic             any_req;

    rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
        .req       (req_valid),
        .last      (last_q),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    // Gated by rst so nothing is offered while reset is held.
    assign req_ready = (state_q == IDLE && rst) ? grant_oh : '0;

    always_comb begin
        state_d  = state_q;
        dp_a_d   = dp_a_q;
        dp_b_d   = dp_b_q;
        rsp_z_d  = rsp_z_q;
        rsp_id_d = rsp_id_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        dp_en_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    dp_a_d   = req_a[int'(grant_idx)*W +: W];
                    dp_b_d   = req_b[int'(grant_idx)*W +: W];
                    rsp_id_d = grant_idx;
                    last_d   = grant_idx;
                    dp_en_d  = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(DP_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    rsp_z_d = dp_z;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            rsp_z_q     <= '0;
            rsp_id_q    <= '0;
            last_q      <= IDW'(N - 1);
            cnt_q       <= '0;
            dp_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            rsp_z_q     <= rsp_z_d;
            rsp_id_q    <= rsp_id_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            dp_en_q     <= dp_en_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign dp_en     = dp_en_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_z     = rsp_z_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_xor_share_ctrl.sv
// Bench for xor_share_ctrl: a DP_LAT=1 instance driven from a cycle table plus
// reset sequences, and a DP_LAT=3 instance for the longer-latency build.
module tb_xor_share_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: DP_LAT=1
    logic [1:0] rv_a, rdy_a;
    logic [7:0] ra_a, rb_a;
    logic [3:0] dpa_a, dpb_a, dpz_a, z_a;
    logic       en_a, vld_a, rr_a, id_a, busy_a;

    // Instance B: DP_LAT=3
    logic [1:0] rv_b, rdy_b;
    logic [7:0] ra_b, rb_b;
    logic [3:0] dpa_b, dpb_b, dpz_b, z_b;
    logic       en_b, vld_b, rr_b, id_b, busy_b;

    xor_share_ctrl #(.N(2), .W(4), .DP_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(rv_a), .req_ready(rdy_a),
        .req_a(ra_a), .req_b(rb_a), .dp_a(dpa_a), .dp_b(dpb_a), .dp_en(en_a),
        .dp_z(dpz_a), .rsp_valid(vld_a), .rsp_ready(rr_a), .rsp_id(id_a),
        .rsp_z(z_a), .busy(busy_a)
    );

    xor_share_ctrl #(.N(2), .W(4), .DP_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .req_valid(rv_b), .req_ready(rdy_b),
        .req_a(ra_b), .req_b(rb_b), .dp_a(dpa_b), .dp_b(dpb_b), .dp_en(en_b),
        .dp_z(dpz_b), .rsp_valid(vld_b), .rsp_ready(rr_b), .rsp_id(id_b),
        .rsp_z(z_b), .busy(busy_b)
    );

    // Behavioural datapaths: result only produced for an enabled cycle.
    logic [3:0] za_q;
    logic [3:0] zb_q [3];
    always @(posedge clk) begin
        za_q     <= en_a ? (dpa_a ^ dpb_a) : 4'h0;
        zb_q[0]  <= en_b ? (dpa_b ^ dpb_b) : 4'h0;
        zb_q[1]  <= zb_q[0];
        zb_q[2]  <= zb_q[1];
    end
    assign dpz_a = za_q;
    assign dpz_b = zb_q[2];

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // {req_ready, dp_en, dp_a, dp_b, rsp_valid, rsp_z, rsp_id, busy}
    function automatic logic [17:0] obs_a();
        return {rdy_a, en_a, dpa_a, dpb_a, vld_a, z_a, id_a, busy_a};
    endfunction
    function automatic logic [17:0] obs_b();
        return {rdy_b, en_b, dpa_b, dpb_b, vld_b, z_b, id_b, busy_b};
    endfunction

    typedef struct {
        logic [1:0]  rv;
        logic [7:0]  a, b;
        logic        rr;
        logic [17:0] exp;
    } vec_t;

    function automatic vec_t v(logic [1:0] rv, logic [7:0] a, logic [7:0] b, logic rr,
                               logic [1:0] rdy, logic en, logic [3:0] dpa, logic [3:0] dpb,
                               logic vld, logic [3:0] z, logic id, logic bsy);
        vec_t r;
        r.rv  = rv;
        r.a   = a;
        r.b   = b;
        r.rr  = rr;
        r.exp = {rdy, en, dpa, dpb, vld, z, id, bsy};
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        int en_cnt, en_at, vld_at;
        logic [3:0] zb_seen;
        logic       idb_seen;

        rv_a = '0; ra_a = '0; rb_a = '0; rr_a = 1'b0;
        rv_b = '0; ra_b = '0; rb_b = '0; rr_b = 1'b0;
        #2 rst = 1'b0;

        // Reset held with random request traffic
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rv_a = 2'($urandom); rr_a = 1'($urandom);
            ra_a = 8'($urandom); rb_a = 8'($urandom);
            rv_b = 2'($urandom);
            #1 chk($sformatf("rst_hold_a%0d", i), 32'(obs_a()), 32'h0);
        end
        chk("rst_hold_b", 32'(obs_b()), 32'h0);
        @(negedge clk);
        rv_a = '0; rv_b = '0; ra_a = '0; rb_a = '0; rst = 1'b1;
        #1 chk("rst_release", 32'(obs_a()), 32'h0);

        // Contention: grants alternate 0,1,0,1, one op every 4 cycles
        for (int k = 0; k < 15; k++) begin
            case (k % 4)
                0: tbl.push_back(v(2'b11, 8'h48, 8'h66, 1'b1, (k % 8 == 0) ? 2'b01 : 2'b10, 1'b0,
                                   (k % 8 == 0) ? 4'h4 : 4'h8, 4'h6, 1'b0,
                                   (k % 8 == 0) ? 4'h2 : 4'hE, (k % 8 == 0) ? 1'b1 : 1'b0, 1'b0));
                1: tbl.push_back(v(2'b11, 8'h48, 8'h66, 1'b1, 2'b00, 1'b1, (k % 8 == 1) ? 4'h8 : 4'h4,
                                   4'h6, 1'b0, (k < 4) ? 4'h0 : ((k % 8 == 1) ? 4'h2 : 4'hE),
                                   (k % 8 == 1) ? 1'b0 : 1'b1, 1'b1));
                2: tbl.push_back(v(2'b11, 8'h48, 8'h66, 1'b1, 2'b00, 1'b0, (k % 8 == 2) ? 4'h8 : 4'h4,
                                   4'h6, 1'b0, (k < 4) ? 4'h0 : ((k % 8 == 2) ? 4'h2 : 4'hE),
                                   (k % 8 == 2) ? 1'b0 : 1'b1, 1'b1));
                default: tbl.push_back(v(2'b11, 8'h48, 8'h66, 1'b1, 2'b00, 1'b0, (k % 8 == 3) ? 4'h8 : 4'h4,
                                   4'h6, 1'b1, (k % 8 == 3) ? 4'hE : 4'h2,
                                   (k % 8 == 3) ? 1'b0 : 1'b1, 1'b1));
            endcase
        end
        // The first IDLE row sees the post-reset zeros
        tbl[0] = v(2'b11, 8'h48, 8'h66, 1'b1, 2'b01, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        tbl.push_back(v(2'b11, 8'h48, 8'h66, 1'b1, 2'b00, 1'b0, 4'h4, 4'h6, 1'b1, 4'h2, 1'b1, 1'b1));
        // Backpressure: five stalled RESP cycles with requests pending
        tbl.push_back(v(2'b01, 8'h48, 8'h66, 1'b0, 2'b01, 1'b0, 4'h4, 4'h6, 1'b0, 4'h2, 1'b1, 1'b0));
        tbl.push_back(v(2'b00, 8'h48, 8'h66, 1'b0, 2'b00, 1'b1, 4'h8, 4'h6, 1'b0, 4'h2, 1'b0, 1'b1));
        tbl.push_back(v(2'b00, 8'h48, 8'h66, 1'b0, 2'b00, 1'b0, 4'h8, 4'h6, 1'b0, 4'h2, 1'b0, 1'b1));
        for (int k = 0; k < 5; k++)
            tbl.push_back(v(2'b11, 8'h48, 8'h66, 1'b0, 2'b00, 1'b0, 4'h8, 4'h6, 1'b1, 4'hE, 1'b0, 1'b1));
        // Response handshake cycle: no accept alongside it
        tbl.push_back(v(2'b11, 8'h48, 8'h66, 1'b1, 2'b00, 1'b0, 4'h8, 4'h6, 1'b1, 4'hE, 1'b0, 1'b1));
        tbl.push_back(v(2'b11, 8'h48, 8'h66, 1'b0, 2'b10, 1'b0, 4'h8, 4'h6, 1'b0, 4'hE, 1'b0, 1'b0));
        tbl.push_back(v(2'b00, 8'h48, 8'h66, 1'b0, 2'b00, 1'b1, 4'h4, 4'h6, 1'b0, 4'hE, 1'b1, 1'b1));
        tbl.push_back(v(2'b00, 8'h48, 8'h66, 1'b1, 2'b00, 1'b0, 4'h4, 4'h6, 1'b0, 4'hE, 1'b1, 1'b1));
        tbl.push_back(v(2'b00, 8'h48, 8'h66, 1'b1, 2'b00, 1'b0, 4'h4, 4'h6, 1'b1, 4'h2, 1'b1, 1'b1));
        tbl.push_back(v(2'b00, 8'h48, 8'h66, 1'b1, 2'b00, 1'b0, 4'h4, 4'h6, 1'b0, 4'h2, 1'b1, 1'b0));
        // Single request: req0 A=0000 B=0110
        tbl.push_back(v(2'b01, 8'h00, 8'h06, 1'b1, 2'b01, 1'b0, 4'h4, 4'h6, 1'b0, 4'h2, 1'b1, 1'b0));
        tbl.push_back(v(2'b00, 8'h00, 8'h06, 1'b1, 2'b00, 1'b1, 4'h0, 4'h6, 1'b0, 4'h2, 1'b0, 1'b1));
        tbl.push_back(v(2'b00, 8'h00, 8'h06, 1'b1, 2'b00, 1'b0, 4'h0, 4'h6, 1'b0, 4'h2, 1'b0, 1'b1));
        tbl.push_back(v(2'b00, 8'h00, 8'h06, 1'b1, 2'b00, 1'b0, 4'h0, 4'h6, 1'b1, 4'h6, 1'b0, 1'b1));
        tbl.push_back(v(2'b00, 8'h00, 8'h06, 1'b1, 2'b00, 1'b0, 4'h0, 4'h6, 1'b0, 4'h6, 1'b0, 1'b0));

        foreach (tbl[i]) begin
            @(negedge clk);
            rv_a = tbl[i].rv; ra_a = tbl[i].a; rb_a = tbl[i].b; rr_a = tbl[i].rr;
            #1 chk($sformatf("row%0d", i), 32'(obs_a()), 32'(tbl[i].exp));
        end

        // Reset in the middle of WAIT; pointer was last at requester 0
        @(negedge clk);
        rv_a = 2'b01; ra_a = 8'h48; rb_a = 8'h66;
        #1 chk("mr_grant", 32'(rdy_a), 32'h1);
        @(negedge clk);
        rv_a = 2'b00;
        #1 chk("mr_issue_en", 32'(en_a), 32'h1);
        @(negedge clk);
        #1 chk("mr_wait_busy", 32'({busy_a, vld_a}), 32'h2);
        #2 rst = 1'b0;
        #1 chk("mr_async_clear", 32'(obs_a()), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rv_a = 2'b11;
            #1 chk($sformatf("mr_hold%0d", i), 32'(obs_a()), 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1 chk("mr_prio0", 32'(rdy_a), 32'h1);
        @(negedge clk);
        rv_a = 2'b00;
        repeat (5) @(negedge clk);
        chk("mr_drain_idle", 32'(busy_a), 32'h0);

        // DP_LAT=3 build: req1 A=0000 B=1110
        @(negedge clk);
        rv_b = 2'b10; ra_b = 8'h00; rb_b = 8'hE0; rr_b = 1'b1;
        #1 chk("l3_grant", 32'(rdy_b), 32'h2);
        en_cnt = 0; en_at = 0; vld_at = 0; zb_seen = '0; idb_seen = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            rv_b = 2'b00;
            #1;
            if (en_b) begin en_cnt++; en_at = c; end
            if (vld_b && vld_at == 0) begin vld_at = c; zb_seen = z_b; idb_seen = id_b; end
        end
        chk("l3_en_count", 32'(en_cnt), 32'd1);
        chk("l3_en_cycle", 32'(en_at), 32'd1);
        chk("l3_rsp_cycle", 32'(vld_at), 32'd5);
        chk("l3_rsp_z", 32'(zb_seen), 32'hE);
        chk("l3_rsp_id", 32'(idb_seen), 32'h1);
        chk("l3_idle", 32'(busy_b), 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/xor_share_ctrl.md
Name: xor_share_ctrl

Overview:
Controller that shares one 4-bit XOR datapath unit between N requesters.
- Arbitrates among the requesters round-robin and latches the winner's operands.
- Issues one enable pulse to the datapath, waits its fixed latency, and returns the result with the requester ID over a valid/ready response channel.
- Sits between the requesting logic and the XOR datapath, and owns the datapath's enable (the C2-style gate).

Parameters:
N, 2, number of requesters (2..8)
W, 4, operand/result width
DP_LAT, 1, datapath latency in cycles from dp_en-high cycle to dp_z valid (1..7)
IDW, $clog2(N) (min 1), width of the requester ID, derived

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  N  per-requester request valid
req_ready  output  N  per-requester accept, one-hot or zero
req_a  input  N*W  operand A; requester i occupies bits [i*W +: W]
req_b  input  N*W  operand B, same packing as req_a
dp_a  output  W  operand A to the datapath
dp_b  output  W  operand B to the datapath
dp_en  output  1  datapath enable, one-cycle pulse per operation
dp_z  input  W  datapath result
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_id  output  IDW  index of the served requester
rsp_z  output  W  result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE.
  - dp_a, dp_b, dp_en, rsp_valid, rsp_id, rsp_z and busy go to 0.
  - The round-robin pointer is set so requester 0 has top priority.
  - Any in-flight operation is discarded.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = first asserted req_valid, searching from (last+1) mod N.
  - req_ready[grant] = 1, driven combinationally. All other req_ready bits are 0.
  - req_ready is all-zero in every other state.
  - On the handshake edge, latch req_a/req_b of the grant into dp_a/dp_b, latch the grant into rsp_id and last, then go to ISSUE.
  - With no req_valid, stay in IDLE.
- ISSUE: dp_en = 1 for exactly this cycle. Load the wait counter with DP_LAT, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reads 1, sample dp_z into rsp_z at the closing edge and go to RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_z and rsp_id are held stable until rsp_ready = 1, then go to IDLE.
- dp_a and dp_b hold the latched operands from the ISSUE cycle until the next grant, so the datapath inputs never glitch mid-operation.
- Latency: with the accept at the edge ending cycle t, dp_en is high in cycle t+1 and rsp_valid first rises in cycle t+2+DP_LAT.
- Minimum issue interval is DP_LAT+3 cycles per operation.
- A requester that drops req_valid before being granted is simply not served; no state is kept for it.
- A request is never accepted in the same cycle as a response handshake; the next accept is earliest in the following IDLE cycle.
- req_valid arriving during ISSUE, WAIT or RESP is held off via req_ready=0. Requesters must keep their operands stable while valid is high.
- No arithmetic is performed in this block; widths pass through unchanged at W.

Decomposition:
- Package xor_share_pkg holds:
  - the state enum: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3
  - default N, W and DP_LAT constants
  - the counter width constant (3 bits)
- Sub-module rr_arbiter (parameter N): inputs req[N] and last[IDW], outputs grant_oh[N], grant_idx[IDW] and any_req. It is purely combinational, and the pointer register lives in xor_share_ctrl.

Test Plan:
The bench attaches a behavioural XOR datapath with registered output (dp_z = dp_a^dp_b, DP_LAT cycles after dp_en).
1. Reset: hold rst=0 with random req_valid -> req_ready=0 and every output 0. Release -> busy=0, still IDLE.
2. Single request: req0 A=0000 B=0110 -> req_ready[0]=1 in the same cycle; dp_en is one pulse with dp_a=0000, dp_b=0110; rsp_valid 3 cycles after accept with rsp_z=0110, rsp_id=0.
3. Contention: both valid continuously, req0 A=1000 B=0110 and req1 A=0100 B=0110, rsp_ready=1 -> grants 0,1,0,1; responses 1110/id0, 0010/id1 alternate, each op 4 cycles apart.
4. Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_z and rsp_id stay stable, req_ready stays 0. Then raise rsp_ready -> IDLE next cycle.
5. Reset mid-WAIT: drive rst=0 asynchronously between edges -> outputs clear immediately, no response is produced. After release, with both valid, requester 0 is granted first.
6. DP_LAT=3 build: req1 A=0000 B=1110 -> dp_en pulse, rsp_valid 5 cycles after accept, rsp_z=1110, rsp_id=1.
